// File: rtl/router_reg.sv
// router_reg: datapath register stage of the 1x3 router.
// Latches the packet header, holds one byte across a FIFO-full stall,
// accumulates packet parity and flags a parity mismatch back to the top level.
module router_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic              detect_add,
  input  logic              lfd_state,
  input  logic              ld_state,
  input  logic              laf_state,
  input  logic              full_state,
  input  logic              rst_int_reg,
  output logic [DATA_W-1:0] dout,
  output logic              parity_done,
  output logic              low_pkt_valid,
  output logic              err
);

  // The FSM strobes are nominally one-hot; they are collapsed to a single
  // decoded state so every register sees the same winner when several are high.
  typedef enum logic [2:0] {
    ST_NONE,
    ST_DECODE,
    ST_LFD,
    ST_LD,
    ST_LAF,
    ST_FULL,
    ST_RST
  } strobe_e;

  strobe_e           st;
  logic [DATA_W-1:0] header_byte;
  logic [DATA_W-1:0] hold_byte;
  logic [DATA_W-1:0] internal_parity;
  logic [DATA_W-1:0] packet_parity;
  logic              parity_load;

  // Priority decode of the FSM strobes, highest-listed strobe wins.
  // NOTE: st is assigned a default before the if-chain, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    st = ST_NONE;
    if (detect_add)       st = ST_DECODE;
    else if (lfd_state)   st = ST_LFD;
    else if (ld_state)    st = ST_LD;
    else if (laf_state)   st = ST_LAF;
    else if (full_state)  st = ST_FULL;
    else if (rst_int_reg) st = ST_RST;
  end

  // The parity byte arrives either directly in load_data (FIFO ready) or
  // from hold_byte in load_after_full when it was stalled on a full FIFO.
  always_comb begin
    parity_load = 1'b0;
    if (st == ST_LD && !fifo_full && !pkt_valid)
      parity_load = 1'b1;
    else if (st == ST_LAF && low_pkt_valid && !parity_done)
      parity_load = 1'b1;
  end

  // Header capture; address 3 is not a valid destination and is never latched.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clock) begin
    if (!resetn)
      header_byte <= '0;
    else if (st == ST_DECODE && pkt_valid && data_in[1:0] != 2'b11)
      header_byte <= data_in;
  end

  // FIFO write data: header first, then payload/parity, replaying the held
  // byte after a stall.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      dout <= '0;
    end else begin
      case (st)
        ST_LFD:  dout <= header_byte;
        ST_LD:   if (!fifo_full) dout <= data_in;
        ST_LAF:  dout <= hold_byte;
        default: ;
      endcase
    end
  end

  // Byte that arrived while the destination FIFO was full.
  always_ff @(posedge clock) begin
    if (!resetn)
      hold_byte <= '0;
    else if (st == ST_LD && fifo_full)
      hold_byte <= data_in;
  end

  // Running XOR of header and payload. A stalled byte is counted when it is
  // captured into hold_byte, so the replay in load_after_full adds nothing.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      internal_parity <= '0;
    end else begin
      case (st)
        ST_DECODE: internal_parity <= '0;
        ST_LFD:    internal_parity <= internal_parity ^ header_byte;
        ST_LD:     if (pkt_valid) internal_parity <= internal_parity ^ data_in;
        default:   ;
      endcase
    end
  end

  // Received parity byte and its sticky capture flag.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      packet_parity <= '0;
      parity_done   <= 1'b0;
    end else if (st == ST_DECODE) begin
      packet_parity <= '0;
      parity_done   <= 1'b0;
    end else if (parity_load) begin
      packet_parity <= (st == ST_LAF) ? hold_byte : data_in;
      parity_done   <= 1'b1;
    end
  end

  // pkt_valid dropped during load_data: the parity byte is in flight.
  always_ff @(posedge clock) begin
    if (!resetn)
      low_pkt_valid <= 1'b0;
    else if (st == ST_LD && !pkt_valid)
      low_pkt_valid <= 1'b1;
    else if (st == ST_RST)
      low_pkt_valid <= 1'b0;
  end

  // Parity compare, valid from the cycle after parity_done rises until the
  // next header.
  always_ff @(posedge clock) begin
    if (!resetn)
      err <= 1'b0;
    else if (st == ST_DECODE)
      err <= 1'b0;
    else if (parity_done)
      err <= (internal_parity != packet_parity);
  end

endmodule

// File: tb/tb_router_reg.sv
// tb_router_reg: scenario tests for router_reg. Expected FIFO write bytes are
// queued as each write cycle is driven and compared when dout updates.
module tb_router_reg;

  logic       clock = 1'b0;
  logic       resetn;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       fifo_full;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
  logic [7:0] dout;
  logic       parity_done, low_pkt_valid, err;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic       wr_now  = 1'b0;
  logic       wr_seen = 1'b0;

  // strobe order {detect_add, lfd, ld, laf, full, rst_int_reg}
  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_DA   = 6'b100000;
  localparam logic [5:0] S_LFD  = 6'b010000;
  localparam logic [5:0] S_LD   = 6'b001000;
  localparam logic [5:0] S_LAF  = 6'b000100;
  localparam logic [5:0] S_FULL = 6'b000010;
  localparam logic [5:0] S_RST  = 6'b000001;

  router_reg #(.DATA_W(8)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .pkt_valid    (pkt_valid),
    .data_in      (data_in),
    .fifo_full    (fifo_full),
    .detect_add   (detect_add),
    .lfd_state    (lfd_state),
    .ld_state     (ld_state),
    .laf_state    (laf_state),
    .full_state   (full_state),
    .rst_int_reg  (rst_int_reg),
    .dout         (dout),
    .parity_done  (parity_done),
    .low_pkt_valid(low_pkt_valid),
    .err          (err)
  );

  always #5 clock = ~clock;

  // scoreboard: a write cycle driven before this edge is compared at the next negedge
  always @(posedge clock) wr_seen <= wr_now;

  always @(negedge clock) begin
    if (wr_seen) begin
      logic [7:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow dout=%02h expected=<none>", dout);
      end else begin
        e = exp_q.pop_front();
        if (dout !== e) begin
          errors++;
          $display("FAIL sb_dout got=%02h expected=%02h", dout, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  // one clock of stimulus; returns at the following negedge
  task automatic cyc(input logic [5:0] s, input logic pv, input logic [7:0] d,
                     input logic ff, input logic wr, input logic [7:0] exp);
    {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg} = s;
    pkt_valid = pv;
    data_in   = d;
    fifo_full = ff;
    wr_now    = wr;
    if (wr) exp_q.push_back(exp);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    for (int i = 0; i < 4; i++)
      cyc(6'($urandom), 1'($urandom), 8'($urandom), 1'($urandom), 1'b0, 8'h00);
    checks++;
    if ({dout, parity_done, low_pkt_valid, err} !== 11'h000) begin
      errors++;
      $display("FAIL reset_outputs got=%03h expected=000", {dout, parity_done, low_pkt_valid, err});
    end
    resetn = 1'b1;
    // header_byte was cleared by reset, so a load_first_data writes 0
    cyc(S_LFD, 1'b1, 8'h5A, 1'b0, 1'b1, 8'h00);
    cyc(S_NONE, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_good_packet();
    cyc(S_DA,  1'b1, 8'h0D, 1'b0, 1'b0, 8'h00);
    cyc(S_LFD, 1'b1, 8'h11, 1'b0, 1'b1, 8'h0D);
    cyc(S_LD,  1'b1, 8'h11, 1'b0, 1'b1, 8'h11);
    cyc(S_LD,  1'b1, 8'h22, 1'b0, 1'b1, 8'h22);
    cyc(S_LD,  1'b1, 8'h33, 1'b0, 1'b1, 8'h33);
    cyc(S_LD,  1'b0, 8'h0D, 1'b0, 1'b1, 8'h0D);
    checks++;
    if ({parity_done, low_pkt_valid, err} !== 3'b110) begin
      errors++;
      $display("FAIL good_parity_flags got=%03b expected=110", {parity_done, low_pkt_valid, err});
    end
    cyc(S_NONE, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL good_err got=%0b expected=0", err);
    end
    cyc(S_RST, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    checks++;
    if (low_pkt_valid !== 1'b0) begin
      errors++;
      $display("FAIL good_lpv_clear got=%0b expected=0", low_pkt_valid);
    end
  endtask

  task automatic test_bad_parity();
    cyc(S_DA,  1'b1, 8'h0D, 1'b0, 1'b0, 8'h00);
    cyc(S_LFD, 1'b1, 8'h11, 1'b0, 1'b1, 8'h0D);
    cyc(S_LD,  1'b1, 8'h11, 1'b0, 1'b1, 8'h11);
    cyc(S_LD,  1'b1, 8'h22, 1'b0, 1'b1, 8'h22);
    cyc(S_LD,  1'b1, 8'h33, 1'b0, 1'b1, 8'h33);
    cyc(S_LD,  1'b0, 8'h0C, 1'b0, 1'b1, 8'h0C);
    checks++;
    if ({parity_done, err} !== 2'b10) begin
      errors++;
      $display("FAIL bad_first_cycle got=%02b expected=10", {parity_done, err});
    end
    for (int i = 0; i < 2; i++) begin
      cyc(S_NONE, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
      checks++;
      if (err !== 1'b1) begin
        errors++;
        $display("FAIL bad_err_hold%0d got=%0b expected=1", i, err);
      end
    end
    cyc(S_DA, 1'b1, 8'h0D, 1'b0, 1'b0, 8'h00);
    checks++;
    if ({parity_done, err} !== 2'b00) begin
      errors++;
      $display("FAIL bad_clear got=%02b expected=00", {parity_done, err});
    end
    cyc(S_RST, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_stall();
    cyc(S_DA,   1'b1, 8'h0D, 1'b0, 1'b0, 8'h00);
    cyc(S_LFD,  1'b1, 8'h11, 1'b0, 1'b1, 8'h0D);
    cyc(S_LD,   1'b1, 8'h11, 1'b0, 1'b1, 8'h11);
    cyc(S_LD,   1'b1, 8'h22, 1'b1, 1'b0, 8'h00);
    checks++;
    if (dout !== 8'h11) begin
      errors++;
      $display("FAIL stall_capture_dout got=%02h expected=11", dout);
    end
    cyc(S_FULL, 1'b1, 8'h22, 1'b1, 1'b0, 8'h00);
    checks++;
    if (dout !== 8'h11) begin
      errors++;
      $display("FAIL stall_full_dout got=%02h expected=11", dout);
    end
    cyc(S_LAF,  1'b1, 8'h22, 1'b0, 1'b1, 8'h22);
    cyc(S_LD,   1'b1, 8'h33, 1'b0, 1'b1, 8'h33);
    cyc(S_LD,   1'b0, 8'h0D, 1'b0, 1'b1, 8'h0D);
    cyc(S_NONE, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    checks++;
    if ({parity_done, err} !== 2'b10) begin
      errors++;
      $display("FAIL stall_parity got=%02b expected=10", {parity_done, err});
    end
    cyc(S_RST, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_stalled_parity();
    cyc(S_DA,   1'b1, 8'h0D, 1'b0, 1'b0, 8'h00);
    cyc(S_LFD,  1'b1, 8'h11, 1'b0, 1'b1, 8'h0D);
    cyc(S_LD,   1'b1, 8'h11, 1'b0, 1'b1, 8'h11);
    cyc(S_LD,   1'b1, 8'h22, 1'b0, 1'b1, 8'h22);
    cyc(S_LD,   1'b1, 8'h33, 1'b0, 1'b1, 8'h33);
    cyc(S_LD,   1'b0, 8'h0D, 1'b1, 1'b0, 8'h00);
    checks++;
    if ({dout, parity_done, low_pkt_valid} !== {8'h33, 2'b01}) begin
      errors++;
      $display("FAIL sp_capture got=%02h/%02b expected=33/01", dout, {parity_done, low_pkt_valid});
    end
    cyc(S_FULL, 1'b0, 8'h0D, 1'b1, 1'b0, 8'h00);
    cyc(S_LAF,  1'b0, 8'h0D, 1'b0, 1'b1, 8'h0D);
    checks++;
    if (parity_done !== 1'b1) begin
      errors++;
      $display("FAIL sp_parity_done got=%0b expected=1", parity_done);
    end
    cyc(S_NONE, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    checks++;
    if ({err, low_pkt_valid} !== 2'b01) begin
      errors++;
      $display("FAIL sp_err_lpv got=%02b expected=01", {err, low_pkt_valid});
    end
    cyc(S_RST, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    checks++;
    if (low_pkt_valid !== 1'b0) begin
      errors++;
      $display("FAIL sp_lpv_clear got=%0b expected=0", low_pkt_valid);
    end
  endtask

  task automatic test_addr3();
    // previous header is 0x0D and dout is 0x0D from the replayed parity byte
    cyc(S_DA, 1'b1, 8'h0F, 1'b0, 1'b0, 8'h00);
    checks++;
    if (dout !== 8'h0D) begin
      errors++;
      $display("FAIL addr3_dout got=%02h expected=0d", dout);
    end
    cyc(S_LFD,  1'b1, 8'h44, 1'b0, 1'b1, 8'h0D);
    cyc(S_NONE, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_mid_reset();
    cyc(S_DA,  1'b1, 8'h0D, 1'b0, 1'b0, 8'h00);
    cyc(S_LFD, 1'b1, 8'h11, 1'b0, 1'b1, 8'h0D);
    cyc(S_LD,  1'b0, 8'h55, 1'b0, 1'b1, 8'h55);
    resetn = 1'b0;
    cyc(S_LD,  1'b0, 8'h66, 1'b0, 1'b0, 8'h00);
    resetn = 1'b1;
    checks++;
    if ({dout, parity_done, low_pkt_valid, err} !== 11'h000) begin
      errors++;
      $display("FAIL midrst_outputs got=%03h expected=000", {dout, parity_done, low_pkt_valid, err});
    end
    // clean packet to address 2: 0E^11^22^33 = 0E
    cyc(S_DA,   1'b1, 8'h0E, 1'b0, 1'b0, 8'h00);
    cyc(S_LFD,  1'b1, 8'h11, 1'b0, 1'b1, 8'h0E);
    cyc(S_LD,   1'b1, 8'h11, 1'b0, 1'b1, 8'h11);
    cyc(S_LD,   1'b1, 8'h22, 1'b0, 1'b1, 8'h22);
    cyc(S_LD,   1'b1, 8'h33, 1'b0, 1'b1, 8'h33);
    cyc(S_LD,   1'b0, 8'h0E, 1'b0, 1'b1, 8'h0E);
    cyc(S_NONE, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    checks++;
    if ({parity_done, err} !== 2'b10) begin
      errors++;
      $display("FAIL midrst_next_pkt got=%02b expected=10", {parity_done, err});
    end
  endtask

  initial begin
    resetn = 1'b0;
    {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg} = S_NONE;
    pkt_valid = 1'b0;
    data_in   = 8'h00;
    fifo_full = 1'b0;
    @(negedge clock);
    test_reset();
    test_good_packet();
    test_bad_parity();
    test_stall();
    test_stalled_parity();
    test_addr3();
    test_mid_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
